// File: rtl/decode_prefix_pkg.sv
// Shared definitions for the decode-stage prefix window: prefix byte codes,
// segment/rep encodings, the scan state enum, prefix group tags and the
// prefix-byte membership test used by the per-byte classifier.
package decode_prefix_pkg;

    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_FS    = 8'h64;
    localparam logic [7:0] PFX_GS    = 8'h65;
    localparam logic [7:0] PFX_OPSZ  = 8'h66;
    localparam logic [7:0] PFX_ADSZ  = 8'h67;
    localparam logic [7:0] ESC_0F    = 8'h0F;

    localparam logic [2:0] SEG_ES   = 3'd0;
    localparam logic [2:0] SEG_CS   = 3'd1;
    localparam logic [2:0] SEG_SS   = 3'd2;
    localparam logic [2:0] SEG_DS   = 3'd3;
    localparam logic [2:0] SEG_FS   = 3'd4;
    localparam logic [2:0] SEG_GS   = 3'd5;
    localparam logic [2:0] SEG_NONE = 3'd7;

    localparam logic [1:0] REP_NONE = 2'd0;
    localparam logic [1:0] REP_F2   = 2'd1;
    localparam logic [1:0] REP_F3   = 2'd2;

    typedef enum logic [1:0] {SCAN, DONE, FAULT} state_t;

    typedef enum logic [2:0] {
        GRP_NONE, GRP_REP, GRP_LOCK, GRP_SEG, GRP_OPSZ, GRP_ADSZ
    } group_t;

    function automatic logic is_prefix_byte(input logic [7:0] b);
        case (b)
            PFX_REPNE, PFX_REP, PFX_LOCK, PFX_ES, PFX_CS, PFX_SS,
            PFX_DS, PFX_FS, PFX_GS, PFX_OPSZ, PFX_ADSZ: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_prefix_classify.sv
// Purpose: classify one fetch byte as prefix/escape and report its group and value.
// Latency: purely combinational.  Backpressure: none, no handshake.
// Ports: byte_dat in; is_prefix, is_escape, group, value (rep code or seg code) out.
module decode_prefix_classify
    import decode_prefix_pkg::*;
(
    input  logic [7:0] byte_dat,
    output logic       is_prefix,
    output logic       is_escape,
    output group_t     group,
    output logic [2:0] value
);

    always_comb begin
        is_prefix = is_prefix_byte(byte_dat);
        is_escape = (byte_dat == ESC_0F);
        group     = GRP_NONE;
        value     = 3'd0;
        case (byte_dat)
            PFX_REPNE: begin group = GRP_REP;  value = {1'b0, REP_F2}; end
            PFX_REP:   begin group = GRP_REP;  value = {1'b0, REP_F3}; end
            PFX_LOCK:  group = GRP_LOCK;
            PFX_ES:    begin group = GRP_SEG;  value = SEG_ES; end
            PFX_CS:    begin group = GRP_SEG;  value = SEG_CS; end
            PFX_SS:    begin group = GRP_SEG;  value = SEG_SS; end
            PFX_DS:    begin group = GRP_SEG;  value = SEG_DS; end
            PFX_FS:    begin group = GRP_SEG;  value = SEG_FS; end
            PFX_GS:    begin group = GRP_SEG;  value = SEG_GS; end
            PFX_OPSZ:  group = GRP_OPSZ;
            PFX_ADSZ:  group = GRP_ADSZ;
            default:   ;
        endcase
    end

endmodule

// File: rtl/decode_prefix_window.sv
// Purpose: consume the leading run of x86 prefix bytes from a fetch window and hold prefix state.
// Latency: consume is combinational from the window; prefix state/flags appear one cycle after acceptance.
// Backpressure: win_ready only in SCAN; held off in DONE until instr_finished, in FAULT until flush.
// Ports: clk, rst (async, active-high), cs_d_b, win_data/win_count/win_valid/win_ready/consume,
//        instr_finished, flush, opcode_ready, operand_32bit, address_32bit, rep, lock, seg,
//        two_byte, prefix_count, length_fault, dup_prefix.
// Optional: define DECODE_PREFIX_DUP_DETECT_EN to build repeated-prefix-group detection;
//        otherwise dup_prefix is tied low.
module decode_prefix_window
    import decode_prefix_pkg::*;
#(
    parameter  int BYTES_PER_CYCLE = 4,
    parameter  int MAX_INSTR_LEN   = 15,
    parameter  int CNT_W           = 4,
    localparam int CW              = $clog2(BYTES_PER_CYCLE + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs_d_b,
    input  logic [8*BYTES_PER_CYCLE-1:0] win_data,
    input  logic [CW-1:0]                win_count,
    input  logic                         win_valid,
    output logic                         win_ready,
    output logic [CW-1:0]                consume,
    input  logic                         instr_finished,
    input  logic                         flush,
    output logic                         opcode_ready,
    output logic                         operand_32bit,
    output logic                         address_32bit,
    output logic [1:0]                   rep,
    output logic                         lock,
    output logic [2:0]                   seg,
    output logic                         two_byte,
    output logic [CNT_W-1:0]             prefix_count,
    output logic                         length_fault,
    output logic                         dup_prefix
);

    logic [BYTES_PER_CYCLE-1:0] cls_pfx;
    logic [BYTES_PER_CYCLE-1:0] cls_esc;
    group_t                     cls_grp [BYTES_PER_CYCLE];
    logic [2:0]                 cls_val [BYTES_PER_CYCLE];

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_cls
        decode_prefix_classify u_cls (
            .byte_dat  (win_data[8*g +: 8]),
            .is_prefix (cls_pfx[g]),
            .is_escape (cls_esc[g]),
            .group     (cls_grp[g]),
            .value     (cls_val[g])
        );
    end

    state_t           state_q, state_d;
    logic [1:0]       rep_q, rep_d;
    logic             lock_q, lock_d;
    logic [2:0]       seg_q, seg_d;
    logic             opsz_q, opsz_d;
    logic             adsz_q, adsz_d;
    logic             two_byte_q, two_byte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DECODE_PREFIX_DUP_DETECT_EN
    logic             dup_q, dup_d;
`endif

    int   cons;       // bytes consumed from this window
    int   limit;      // bytes still allowed before the length limit
    logic stop;
    logic opcode_found;

    always_comb begin
        state_d      = state_q;
        rep_d        = rep_q;
        lock_d       = lock_q;
        seg_d        = seg_q;
        opsz_d       = opsz_q;
        adsz_d       = adsz_q;
        two_byte_d   = two_byte_q;
        cnt_d        = cnt_q;
`ifdef DECODE_PREFIX_DUP_DETECT_EN
        dup_d        = dup_q;
`endif
        cons         = 0;
        limit        = MAX_INSTR_LEN - int'(cnt_q);
        stop         = 1'b0;
        opcode_found = 1'b0;

        if (flush || (instr_finished && state_q != FAULT)) begin
            // FAULT is sticky against instr_finished; only flush leaves it.
            state_d    = SCAN;
            rep_d      = REP_NONE;
            lock_d     = 1'b0;
            seg_d      = SEG_NONE;
            opsz_d     = 1'b0;
            adsz_d     = 1'b0;
            two_byte_d = 1'b0;
            cnt_d      = '0;
`ifdef DECODE_PREFIX_DUP_DETECT_EN
            dup_d      = 1'b0;
`endif
        end else if (state_q == SCAN && win_valid) begin
            for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
                if (!stop && i < int'(win_count)) begin
                    if (cons >= limit) begin
                        // Length limit reached: stop without claiming an opcode.
                        stop = 1'b1;
                    end else if (two_byte_d) begin
                        // Byte following 0Fh is the opcode, whatever its value.
                        stop         = 1'b1;
                        opcode_found = 1'b1;
                    end else if (cls_esc[i]) begin
                        two_byte_d = 1'b1;
                        cons       = cons + 1;
                    end else if (cls_pfx[i]) begin
`ifdef DECODE_PREFIX_DUP_DETECT_EN
                        case (cls_grp[i])
                            GRP_REP:  if (rep_d != REP_NONE) dup_d = 1'b1;
                            GRP_LOCK: if (lock_d)            dup_d = 1'b1;
                            GRP_SEG:  if (seg_d != SEG_NONE) dup_d = 1'b1;
                            GRP_OPSZ: if (opsz_d)            dup_d = 1'b1;
                            GRP_ADSZ: if (adsz_d)            dup_d = 1'b1;
                            default:  ;
                        endcase
`endif
                        // Later bytes overwrite earlier ones in the same group.
                        case (cls_grp[i])
                            GRP_REP:  rep_d  = cls_val[i][1:0];
                            GRP_LOCK: lock_d = 1'b1;
                            GRP_SEG:  seg_d  = cls_val[i];
                            GRP_OPSZ: opsz_d = 1'b1;
                            GRP_ADSZ: adsz_d = 1'b1;
                            default:  ;
                        endcase
                        cons = cons + 1;
                    end else begin
                        stop         = 1'b1;
                        opcode_found = 1'b1;
                    end
                end
            end
            // cons never exceeds limit, so the count saturates at the limit.
            cnt_d = CNT_W'(int'(cnt_q) + cons);
            if (int'(cnt_q) + cons >= MAX_INSTR_LEN) begin
                state_d = FAULT;
            end else if (opcode_found) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            rep_q      <= REP_NONE;
            lock_q     <= 1'b0;
            seg_q      <= SEG_NONE;
            opsz_q     <= 1'b0;
            adsz_q     <= 1'b0;
            two_byte_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rep_q      <= rep_d;
            lock_q     <= lock_d;
            seg_q      <= seg_d;
            opsz_q     <= opsz_d;
            adsz_q     <= adsz_d;
            two_byte_q <= two_byte_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef DECODE_PREFIX_DUP_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_d;
        end
    end
    assign dup_prefix = dup_q;
`else
    assign dup_prefix = 1'b0;
`endif

    assign win_ready     = (state_q == SCAN);
    assign opcode_ready  = (state_q == DONE);
    assign length_fault  = (state_q == FAULT);
    assign consume       = CW'(cons);
    assign operand_32bit = cs_d_b ^ opsz_q;
    assign address_32bit = cs_d_b ^ adsz_q;
    assign rep           = rep_q;
    assign lock          = lock_q;
    assign seg           = seg_q;
    assign two_byte      = two_byte_q;
    assign prefix_count  = cnt_q;

endmodule

// File: tb/tb_decode_prefix_window.sv
module tb_decode_prefix_window;

    localparam int BPC  = 4;
    localparam int MAXL = 15;
    localparam int CW   = 3;
`ifdef DECODE_PREFIX_DUP_DETECT_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_d_b;
    logic [31:0] win_data;
    logic [CW-1:0] win_count;
    logic        win_valid;
    logic        win_ready;
    logic [CW-1:0] consume;
    logic        instr_finished;
    logic        flush;
    logic        opcode_ready;
    logic        operand_32bit;
    logic        address_32bit;
    logic [1:0]  rep;
    logic        lock;
    logic [2:0]  seg;
    logic        two_byte;
    logic [3:0]  prefix_count;
    logic        length_fault;
    logic        dup_prefix;

    always #5 clk = ~clk;

    decode_prefix_window #(
        .BYTES_PER_CYCLE (BPC),
        .MAX_INSTR_LEN   (MAXL),
        .CNT_W           (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cs_d_b         (cs_d_b),
        .win_data       (win_data),
        .win_count      (win_count),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .consume        (consume),
        .instr_finished (instr_finished),
        .flush          (flush),
        .opcode_ready   (opcode_ready),
        .operand_32bit  (operand_32bit),
        .address_32bit  (address_32bit),
        .rep            (rep),
        .lock           (lock),
        .seg            (seg),
        .two_byte       (two_byte),
        .prefix_count   (prefix_count),
        .length_fault   (length_fault),
        .dup_prefix     (dup_prefix)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // st: 0 scan, 1 done, 2 fault. op/ad are the "prefix seen" flags.
    task automatic chk_outs(input string tag, input int st, input int pc, input int r,
                            input int sg, input bit lk, input bit tw, input bit op,
                            input bit ad, input bit dp);
        chk({tag, ".win_ready"},    32'(win_ready),     32'(st == 0));
        chk({tag, ".opcode_ready"}, 32'(opcode_ready),  32'(st == 1));
        chk({tag, ".length_fault"}, 32'(length_fault),  32'(st == 2));
        chk({tag, ".prefix_count"}, 32'(prefix_count),  32'(pc));
        chk({tag, ".rep"},          32'(rep),           32'(r));
        chk({tag, ".seg"},          32'(seg),           32'(sg));
        chk({tag, ".lock"},         32'(lock),          32'(lk));
        chk({tag, ".two_byte"},     32'(two_byte),      32'(tw));
        chk({tag, ".operand_32"},   32'(operand_32bit), 32'(cs_d_b ^ op));
        chk({tag, ".address_32"},   32'(address_32bit), 32'(cs_d_b ^ ad));
        chk({tag, ".dup_prefix"},   32'(dup_prefix),    32'(dp));
    endtask

    // ---------------- reference model: list of bytes eaten by this instruction
    logic [7:0] mq[$];
    int         ms;

    function automatic int grp(input logic [7:0] b);
        case (b)
            8'hF2, 8'hF3:                               return 1;
            8'hF0:                                      return 2;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65:   return 3;
            8'h66:                                      return 4;
            8'h67:                                      return 5;
            default:                                    return 0;
        endcase
    endfunction

    function automatic bit has_byte(input logic [7:0] v);
        foreach (mq[k]) if (mq[k] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_step(input logic [31:0] w, input int cnt, input bit vld,
                                      input bit fin, input bit fl);
        int n = 0;
        bit found = 1'b0;
        bit esc;
        logic [7:0] b;
        if (fl || (fin && ms != 2)) begin
            mq.delete();
            ms = 0;
            return 0;
        end
        if (ms != 0 || !vld) return 0;
        esc = has_byte(8'h0F);
        for (int i = 0; i < cnt; i++) begin
            b = w[8*i +: 8];
            if (mq.size() >= MAXL) break;
            if (esc || (grp(b) == 0 && b != 8'h0F)) begin
                found = 1'b1;
                break;
            end
            mq.push_back(b);
            n++;
            if (b == 8'h0F) esc = 1'b1;
        end
        if (mq.size() >= MAXL) ms = 2;
        else if (found)        ms = 1;
        return n;
    endfunction

    task automatic chk_model(input string tag);
        int r = 0, sg = 7;
        bit lk = 0, tw = 0, op = 0, ad = 0, dp = 0;
        int cg [6] = '{default: 0};
        foreach (mq[k]) begin
            case (mq[k])
                8'hF2: r = 1;
                8'hF3: r = 2;
                8'hF0: lk = 1;
                8'h26: sg = 0;
                8'h2E: sg = 1;
                8'h36: sg = 2;
                8'h3E: sg = 3;
                8'h64: sg = 4;
                8'h65: sg = 5;
                8'h66: op = 1;
                8'h67: ad = 1;
                8'h0F: tw = 1;
                default: ;
            endcase
            cg[grp(mq[k])]++;
        end
        for (int g = 1; g < 6; g++) if (cg[g] > 1) dp = DUP_EN;
        chk_outs(tag, ms, mq.size(), r, sg, lk, tw, op, ad, dp);
    endtask

    // ---------------- directed table
    typedef struct {
        logic [31:0] win;
        int          cnt;
        bit          vld, fin, fl;
        int          e_cons, e_st, e_pc, e_rep, e_seg;
        bit          e_lk, e_tw, e_op, e_ad, e_dp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] w, input int c, input bit v, input bit f,
                                input bit fl, input int ec, input int st, input int pc,
                                input int r, input int sg, input bit lk, input bit tw,
                                input bit op, input bit ad, input bit dp);
        vec_t t;
        t.win = w; t.cnt = c; t.vld = v; t.fin = f; t.fl = fl;
        t.e_cons = ec; t.e_st = st; t.e_pc = pc; t.e_rep = r; t.e_seg = sg;
        t.e_lk = lk; t.e_tw = tw; t.e_op = op; t.e_ad = ad; t.e_dp = dp;
        return t;
    endfunction

    task automatic drive(input logic [31:0] w, input int c, input bit v, input bit f,
                         input bit fl);
        win_data       = w;
        win_count      = CW'(c);
        win_valid      = v;
        instr_finished = f;
        flush          = fl;
    endtask

    logic [7:0] pool [16] = '{8'hF2, 8'hF3, 8'hF0, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64,
                              8'h65, 8'h66, 8'h67, 8'h0F, 8'h8B, 8'h90, 8'hC3, 8'h00};

    initial begin
        //            win           cnt v f fl  cons st pc rep seg lk tw op ad dp
        tbl.push_back(mk(32'h908B2E66, 4, 1, 0, 0, 2, 1, 2,  0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(32'h00000000, 0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00A4F2F3, 3, 1, 0, 0, 2, 1, 2,  1, 7, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h00000000, 0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h26262626, 4, 1, 0, 0, 4, 0, 4,  0, 0, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h26262626, 4, 1, 0, 0, 4, 0, 8,  0, 0, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h26262626, 4, 1, 0, 0, 4, 0, 12, 0, 0, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h26262626, 4, 1, 0, 0, 3, 2, 15, 0, 0, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h26262626, 4, 1, 0, 0, 0, 2, 15, 0, 0, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h00000000, 0, 0, 0, 1, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00000F0F, 2, 1, 0, 0, 1, 1, 1,  0, 7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00000000, 0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h000000F0, 1, 1, 0, 0, 1, 0, 1,  0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk(32'h0000C186, 2, 1, 0, 0, 0, 1, 1,  0, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00000000, 0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00000067, 0, 1, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h0000000F, 1, 1, 0, 0, 1, 0, 1,  0, 7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00000F0F, 2, 1, 0, 0, 0, 1, 1,  0, 7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00000000, 0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h363E6465, 4, 1, 0, 0, 4, 0, 4,  0, 2, 0, 0, 0, 0, DUP_EN));
        tbl.push_back(mk(32'h0000C367, 2, 1, 0, 0, 1, 1, 5,  0, 2, 0, 0, 0, 1, DUP_EN));
        tbl.push_back(mk(32'h00000066, 1, 1, 1, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00000066, 1, 1, 0, 0, 1, 0, 1,  0, 7, 0, 0, 1, 0, 0));
        tbl.push_back(mk(32'h00000066, 1, 1, 0, 1, 0, 0, 0,  0, 7, 0, 0, 0, 0, 0));

        // Reset state, including the combinational cs_d_b dependence.
        rst = 1'b1;
        cs_d_b = 1'b0;
        drive(32'h0, 0, 0, 0, 0);
        #1;
        chk_outs("reset", 0, 0, 0, 7, 0, 0, 0, 0, 0);
        cs_d_b = 1'b1;
        #1;
        chk_outs("reset_dbit", 0, 0, 0, 7, 0, 0, 0, 0, 0);
        cs_d_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].win, tbl[k].cnt, tbl[k].vld, tbl[k].fin, tbl[k].fl);
            #1;
            chk($sformatf("tbl%0d.consume", k), 32'(consume), 32'(tbl[k].e_cons));
            @(posedge clk);
            @(negedge clk);
            chk_outs($sformatf("tbl%0d", k), tbl[k].e_st, tbl[k].e_pc, tbl[k].e_rep,
                     tbl[k].e_seg, tbl[k].e_lk, tbl[k].e_tw, tbl[k].e_op, tbl[k].e_ad,
                     tbl[k].e_dp);
        end

        // Asynchronous reset while DONE with seg=FS.
        drive(32'h00009064, 2, 1, 0, 0);
        #1;
        chk("arst.consume", 32'(consume), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0, 0, 0, 0, 0);
        chk_outs("arst.pre", 1, 1, 0, 4, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("arst.post", 0, 0, 0, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        ms = 0;

        // Randomized windows against the byte-list model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            int c, ec;
            bit v, f, fl;
            for (int b = 0; b < BPC; b++) w[8*b +: 8] = pool[$urandom_range(0, 15)];
            c  = $urandom_range(0, BPC);
            v  = ($urandom_range(0, 9) < 8);
            f  = ($urandom_range(0, 19) == 0) || (ms == 1 && $urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 49) == 0) || (ms == 2 && $urandom_range(0, 3) == 0);
            cs_d_b = 1'($urandom_range(0, 1));
            drive(w, c, v, f, fl);
            ec = model_step(w, c, v, f, fl);
            #1;
            chk("rnd.consume", 32'(consume), 32'(ec));
            @(posedge clk);
            @(negedge clk);
            chk_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
